ble_link_monitor: RTL and testbench
===================================

BLE_LINK_MONITOR -- requirements
Module: ble_link_monitor

Interface
REQ-001 SHALL have parameter ADDR_BYTES, default 6: peer address length in bytes.
REQ-002 SHALL have parameter TMR_W, default 24: timer and limit width.
REQ-003 SHALL have parameter MAX_RETRY, default 3: advertise restarts before a timeout is declared.
REQ-004 SHALL have parameter REG_BASE, default 8'h20: special-register address of peer address byte 0.
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 rx_data  in  8  UART RX byte.
REQ-008 rx_valid  in  1  rx_data present.
REQ-009 rx_ready  out  1  byte accepted when rx_valid&&rx_ready.
REQ-010 setup_done  in  1  BLE setup complete; advertising started.
REQ-011 adv_time / conn_time  in  TMR_W each  advertise / connected-inactivity limits in clocks; 0 = never expire.
REQ-012 reg_wr_en, reg_wr_addr[7:0], reg_wr_data[7:0]  out  special-register write port, one write per cycle.
REQ-013 connected  out  1  level, high in CONNECTED.
REQ-014 disconnect, timeout, adv_restart, addr_err  out  1 each  single-cycle pulses.
REQ-015 disc_cause  out  2  1=OK+DISC, 2=OK+LOST, 3=inactivity; held until next disconnect.
REQ-016 retry_cnt  out  $clog2(MAX_RETRY+1)  restarts used in current attempt.

Function
REQ-017 States SHALL be IDLE, ADVERTISE, PARSE_ADDR, STORE_ADDR, CONNECTED, DISCONNECT.
REQ-018 rx_ready SHALL be 1 in every state except STORE_ADDR.
REQ-019 Accepted bytes SHALL shift into a 7-byte window; window cleared on entry to ADVERTISE.
REQ-020 IDLE -> ADVERTISE when setup_done=1; setup_done ignored elsewhere.
REQ-021 ADVERTISE -> PARSE_ADDR the cycle after the byte completing "OK+CONN" is accepted.
REQ-022 PARSE_ADDR: bytes before ':' ignored; after ':' expect 2*ADDR_BYTES hex chars (0-9, A-F, a-f), then 0x0D, then 0x0A.
REQ-023 Any unexpected byte after ':' SHALL pulse addr_err next cycle and restart the parser awaiting ':', staying in PARSE_ADDR.
REQ-024 On LF accepted (cycle N): STORE_ADDR; reg_wr_en high cycles N+1..N+ADDR_BYTES, address REG_BASE+i, data byte i, byte 0 = first two hex chars (high nibble first).
REQ-025 connected SHALL rise at cycle N+ADDR_BYTES+1.
REQ-026 "OK+DISC" or "OK+LOST" completed in PARSE_ADDR SHALL abort to ADVERTISE, no register writes.
REQ-027 Timer SHALL clear on every state change and count each cycle in ADVERTISE, PARSE_ADDR, CONNECTED; expiry when count reaches limit-1 with limit nonzero.
REQ-028 In CONNECTED every accepted byte SHALL clear the timer.
REQ-029 Expiry in ADVERTISE/PARSE_ADDR: if retry_cnt<MAX_RETRY pulse adv_restart, increment retry_cnt, re-enter ADVERTISE; else pulse timeout, go IDLE.
REQ-030 CONNECTED -> DISCONNECT on "OK+DISC", "OK+LOST" or expiry, disc_cause set accordingly; DISCONNECT pulses disconnect one cycle, then IDLE.
REQ-031 Pattern completion and timer expiry in the same cycle: pattern SHALL win.
REQ-032 retry_cnt SHALL clear on entry to IDLE and CONNECTED.

Reset
REQ-033 On rst_n low, regardless of state: IDLE; window, parser, timer cleared; all pulses, reg_wr_en, connected = 0; reg_wr_addr=REG_BASE, reg_wr_data=0, disc_cause=0, retry_cnt=0; rx_ready=1.
REQ-034 Reset mid-STORE_ADDR SHALL abort remaining writes; no write issued until a new parse completes.

Structure
REQ-035 State enum, disc_cause encodings, pattern byte constants SHALL live in the shared BLE package.
REQ-036 Timer SHALL be sub-module ble_link_timer (clear, enable, limit, expired), parametrised by TMR_W.
REQ-037 Hex decode SHALL be a package function.

Verification
REQ-038 setup_done, "OK+CONN:A1B2C3D4E5F6\r\n" -> writes 0x20..0x25 = A1,B2,C3,D4,E5,F6 on consecutive cycles, connected=1 next.
REQ-039 adv_time=100, no input, MAX_RETRY=3 -> adv_restart at ~100,200,300 clocks, timeout pulse at ~400, IDLE.
REQ-040 Connected, "OK+LOST" -> disconnect pulse, disc_cause=2, connected=0; conn_time=50 with silence -> disc_cause=3.
REQ-041 "OK+CONN:A1G2..." -> addr_err pulse at 'G', no writes; then valid address -> normal store.
REQ-042 Last "OK+DISC" byte in expiry cycle -> disc_cause=1; rst_n low after 2nd write -> no further writes, all outputs reset values.

Source files
------------

// File: rtl/ble_link_monitor_pkg.sv
// Shared BLE link-monitor definitions: FSM states, disconnect causes,
// AT-response patterns and the ASCII hex decoder.
package ble_link_monitor_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADV   = 3'd1;
  localparam logic [2:0] ST_PARSE = 3'd2;
  localparam logic [2:0] ST_STORE = 3'd3;
  localparam logic [2:0] ST_CONN  = 3'd4;
  localparam logic [2:0] ST_DISC  = 3'd5;

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_DISC  = 2'd1;
  localparam logic [1:0] CAUSE_LOST  = 2'd2;
  localparam logic [1:0] CAUSE_INACT = 2'd3;

  // Address parser phases
  localparam logic [1:0] PH_WAIT = 2'd0;
  localparam logic [1:0] PH_HEX  = 2'd1;
  localparam logic [1:0] PH_CR   = 2'd2;
  localparam logic [1:0] PH_LF   = 2'd3;

  localparam logic [55:0] PAT_CONN = 56'h4F4B2B434F4E4E; // "OK+CONN"
  localparam logic [55:0] PAT_DISC = 56'h4F4B2B44495343; // "OK+DISC"
  localparam logic [55:0] PAT_LOST = 56'h4F4B2B4C4F5354; // "OK+LOST"

  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

  // {valid, nibble}; valid=0 for anything outside 0-9 / A-F / a-f
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    logic [4:0] r;
    r = 5'd0;
    if (c >= 8'h30 && c <= 8'h39)
      r = {1'b1, c[3:0]};
    else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
      r = {1'b1, c[3:0] + 4'd9};
    return r;
  endfunction

endpackage

// File: rtl/ble_link_monitor_if.sv
// UART RX byte stream and special-register write port of the link monitor.
interface ble_link_monitor_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       reg_wr_en;
  logic [7:0] reg_wr_addr;
  logic [7:0] reg_wr_data;

  modport master (input rx_data, rx_valid,
                  output rx_ready, reg_wr_en, reg_wr_addr, reg_wr_data);
  modport slave  (output rx_data, rx_valid,
                  input rx_ready, reg_wr_en, reg_wr_addr, reg_wr_data);
endinterface

// File: rtl/ble_link_monitor_timer.sv
// Cycle counter with synchronous clear; expired flags count == limit-1.
module ble_link_timer #(
  parameter int TMR_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [TMR_W-1:0] limit,
  output logic             expired
);
  logic [TMR_W-1:0] count;

  // A zero limit disables expiry entirely
  assign expired = enable && (limit != '0) && (count == limit - 1'b1);

  // Clear wins over counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + 1'b1;
  end
endmodule

// File: rtl/ble_link_monitor.sv
// BLE link monitor: watches AT responses from the module UART, extracts the
// peer address after "OK+CONN", writes it to special registers and tracks
// the connection with advertise / inactivity timeouts.
module ble_link_monitor
  import ble_link_monitor_pkg::*;
#(
  parameter int         ADDR_BYTES = 6,
  parameter int         TMR_W      = 24,
  parameter int         MAX_RETRY  = 3,
  parameter logic [7:0] REG_BASE   = 8'h20
) (
  input  logic                             clk,
  input  logic                             rst_n,
  ble_link_monitor_if.master               bus,
  input  logic                             setup_done,
  input  logic [TMR_W-1:0]                 adv_time,
  input  logic [TMR_W-1:0]                 conn_time,
  output logic                             connected,
  output logic                             disconnect,
  output logic                             timeout,
  output logic                             adv_restart,
  output logic                             addr_err,
  output logic [1:0]                       disc_cause,
  output logic [$clog2(MAX_RETRY+1)-1:0]   retry_cnt
);
  localparam int RW = $clog2(MAX_RETRY+1);
  localparam int AW = 8*ADDR_BYTES;
  localparam int HW = $clog2(2*ADDR_BYTES+1);
  localparam int WW = $clog2(ADDR_BYTES+1);
  localparam logic [RW-1:0] MAX_R    = RW'(MAX_RETRY);
  localparam logic [HW-1:0] HEX_LAST = HW'(2*ADDR_BYTES-1);
  localparam logic [WW-1:0] WR_LAST  = WW'(ADDR_BYTES-1);

  logic [2:0]    state, nxt;
  logic [47:0]   hist;      // previous 6 bytes; with the incoming byte forms the 7-byte window
  logic [55:0]   win;
  logic [1:0]    ph, ph_nx;
  logic [HW-1:0] hcnt, hcnt_nx;
  logic [AW-1:0] addr_sr, sr_nx;
  logic [WW-1:0] wcnt;
  logic [1:0]    cause_nx;
  logic [4:0]    hex;
  logic          rx_ready, accept, m_conn, m_disc, m_lost;
  logic          enter_adv, do_restart, do_timeout, p_err, tmo_path;
  logic          t_clear, t_en, expired;
  logic          wr_en;
  logic [7:0]    wr_addr, wr_data;

  assign rx_ready        = (state != ST_STORE);
  assign bus.rx_ready    = rx_ready;
  assign bus.reg_wr_en   = wr_en;
  assign bus.reg_wr_addr = wr_addr;
  assign bus.reg_wr_data = wr_data;
  assign connected       = (state == ST_CONN);
  assign disconnect      = (state == ST_DISC);

  assign accept = bus.rx_valid && rx_ready;
  assign win    = {hist, bus.rx_data};
  assign m_conn = accept && (win == PAT_CONN);
  assign m_disc = accept && (win == PAT_DISC);
  assign m_lost = accept && (win == PAT_LOST);
  assign hex    = hex_decode(bus.rx_data);

  assign t_en    = (state == ST_ADV) || (state == ST_PARSE) || (state == ST_CONN);
  assign t_clear = (nxt != state) || enter_adv || ((state == ST_CONN) && accept);

  ble_link_timer #(.TMR_W(TMR_W)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (t_clear),
    .enable  (t_en),
    .limit   ((state == ST_CONN) ? conn_time : adv_time),
    .expired (expired)
  );

  // Next state, parser step and event decode; patterns outrank timer expiry
  always_comb begin
    nxt        = state;
    enter_adv  = 1'b0;
    do_restart = 1'b0;
    do_timeout = 1'b0;
    tmo_path   = 1'b0;
    p_err      = 1'b0;
    ph_nx      = PH_WAIT;
    hcnt_nx    = '0;
    sr_nx      = addr_sr;
    cause_nx   = disc_cause;
    case (state)
      ST_IDLE:  if (setup_done) begin nxt = ST_ADV; enter_adv = 1'b1; end
      ST_ADV: begin
        if (m_conn)       nxt = ST_PARSE;
        else if (expired) tmo_path = 1'b1;
      end
      ST_PARSE: begin
        if (m_disc || m_lost) begin
          nxt       = ST_ADV;
          enter_adv = 1'b1;
        end else if (expired) begin
          tmo_path = 1'b1;
        end else begin
          ph_nx   = ph;
          hcnt_nx = hcnt;
          if (accept) begin
            case (ph)
              PH_WAIT: if (bus.rx_data == CH_COLON) ph_nx = PH_HEX;
              PH_HEX: begin
                if (hex[4]) begin
                  sr_nx   = {addr_sr[AW-5:0], hex[3:0]};
                  hcnt_nx = hcnt + 1'b1;
                  if (hcnt == HEX_LAST) ph_nx = PH_CR;
                end else p_err = 1'b1;
              end
              PH_CR: if (bus.rx_data == CH_CR) ph_nx = PH_LF; else p_err = 1'b1;
              PH_LF: begin
                if (bus.rx_data == CH_LF) begin
                  nxt     = ST_STORE;
                  ph_nx   = PH_WAIT;
                  hcnt_nx = '0;
                end else p_err = 1'b1;
              end
              default: p_err = 1'b1;
            endcase
            if (p_err) begin ph_nx = PH_WAIT; hcnt_nx = '0; end
          end
        end
      end
      ST_STORE: if (wcnt == WR_LAST) nxt = ST_CONN;
      ST_CONN: begin
        if (m_disc)       begin nxt = ST_DISC; cause_nx = CAUSE_DISC;  end
        else if (m_lost)  begin nxt = ST_DISC; cause_nx = CAUSE_LOST;  end
        else if (expired) begin nxt = ST_DISC; cause_nx = CAUSE_INACT; end
      end
      ST_DISC:  nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
    if (tmo_path) begin
      if (retry_cnt < MAX_R) begin
        do_restart = 1'b1;
        enter_adv  = 1'b1;
        nxt        = ST_ADV;
      end else begin
        do_timeout = 1'b1;
        nxt        = ST_IDLE;
      end
    end
  end

  // State, window, parser, register-write sequencing and pulse outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      hist        <= '0;
      ph          <= PH_WAIT;
      hcnt        <= '0;
      addr_sr     <= '0;
      wcnt        <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= REG_BASE;
      wr_data     <= 8'h00;
      disc_cause  <= CAUSE_NONE;
      retry_cnt   <= '0;
      adv_restart <= 1'b0;
      timeout     <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      state <= nxt;
      if (enter_adv)   hist <= '0;
      else if (accept) hist <= win[47:0];
      ph   <= ph_nx;
      hcnt <= hcnt_nx;
      // Byte 0 (first two hex chars) sits at the top of the shift register
      if (state == ST_PARSE && nxt == ST_STORE) begin
        wr_en   <= 1'b1;
        wr_addr <= REG_BASE;
        wr_data <= sr_nx[AW-1 -: 8];
        addr_sr <= sr_nx << 8;
        wcnt    <= '0;
      end else if (state == ST_STORE && nxt == ST_STORE) begin
        wr_addr <= wr_addr + 8'd1;
        wr_data <= addr_sr[AW-1 -: 8];
        addr_sr <= addr_sr << 8;
        wcnt    <= wcnt + 1'b1;
      end else begin
        wr_en   <= 1'b0;
        addr_sr <= sr_nx;
      end
      disc_cause <= cause_nx;
      if (nxt == ST_IDLE || nxt == ST_CONN) retry_cnt <= '0;
      else if (do_restart)                  retry_cnt <= retry_cnt + 1'b1;
      adv_restart <= do_restart;
      timeout     <= do_timeout;
      addr_err    <= p_err;
    end
  end
endmodule

// File: tb/tb_ble_link_monitor.sv
// Directed bench for ble_link_monitor: connect/store, retries, disconnect
// causes, address errors, pattern-vs-expiry priority and reset mid-store.
module tb_ble_link_monitor;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        setup_done = 1'b0;
  logic [23:0] adv_time = 24'd0;
  logic [23:0] conn_time = 24'd0;
  logic        connected, disconnect, timeout, adv_restart, addr_err;
  logic [1:0]  disc_cause;
  logic [1:0]  retry_cnt;
  int tests = 0;
  int fails = 0;

  ble_link_monitor_if bus();

  ble_link_monitor dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .setup_done(setup_done),
    .adv_time(adv_time), .conn_time(conn_time), .connected(connected),
    .disconnect(disconnect), .timeout(timeout), .adv_restart(adv_restart),
    .addr_err(addr_err), .disc_cause(disc_cause), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  logic [7:0] exp_b [6] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
  localparam string ADDR_STR = ":A1B2C3D4E5F6\r\n";

  // Event logger, sampled on the falling edge (cycle index n)
  int n = 0;
  int wr_cyc[$];
  logic [7:0] wr_addr[$];
  logic [7:0] wr_data[$];
  int rs_cyc[$];
  int rs_cnt[$];
  int lf_cyc, g_cyc, conn_cyc, set_cyc, to_cyc, dc_cyc, ae_cyc;
  int to_n, dc_n, ae_n;
  logic conn_q = 1'b0;

  always @(negedge clk) begin
    n++;
    if (bus.reg_wr_en) begin
      wr_cyc.push_back(n); wr_addr.push_back(bus.reg_wr_addr); wr_data.push_back(bus.reg_wr_data);
    end
    if (bus.rx_valid && bus.rx_ready) begin
      if (bus.rx_data == 8'h0A) lf_cyc = n;
      if (bus.rx_data == 8'h47) g_cyc = n;
    end
    if (connected && !conn_q) conn_cyc = n;
    conn_q = connected;
    if (setup_done) set_cyc = n;
    if (adv_restart) begin rs_cyc.push_back(n); rs_cnt.push_back(int'(retry_cnt)); end
    if (timeout) begin to_cyc = n; to_n++; end
    if (disconnect) begin dc_cyc = n; dc_n++; end
    if (addr_err) begin ae_cyc = n; ae_n++; end
  end

  task automatic clear_logs();
    wr_cyc.delete(); wr_addr.delete(); wr_data.delete(); rs_cyc.delete(); rs_cnt.delete();
    lf_cyc = -1; g_cyc = -1; conn_cyc = -1; set_cyc = -1; to_cyc = -1; dc_cyc = -1; ae_cyc = -1;
    to_n = 0; dc_n = 0; ae_n = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00; setup_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data = b; bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic start_adv();
    setup_done = 1'b1;
    @(posedge clk); #1;
    setup_done = 1'b0;
  endtask

  task automatic test_reset();
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    tests++; if (bus.rx_ready !== 1'b1) begin fails++; $display("FAIL reset_rx_ready: got %b want 1", bus.rx_ready); end
    tests++; if (bus.reg_wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en: got %b want 0", bus.reg_wr_en); end
    tests++; if (bus.reg_wr_addr !== 8'h20) begin fails++; $display("FAIL reset_wr_addr: got %h want 20", bus.reg_wr_addr); end
    tests++; if (bus.reg_wr_data !== 8'h00) begin fails++; $display("FAIL reset_wr_data: got %h want 00", bus.reg_wr_data); end
    tests++; if (connected !== 1'b0) begin fails++; $display("FAIL reset_connected: got %b want 0", connected); end
    tests++; if ({disconnect, timeout, adv_restart, addr_err} !== 4'b0) begin fails++; $display("FAIL reset_pulses: got %b want 0000", {disconnect, timeout, adv_restart, addr_err}); end
    tests++; if (disc_cause !== 2'd0) begin fails++; $display("FAIL reset_disc_cause: got %0d want 0", disc_cause); end
    tests++; if (retry_cnt !== 2'd0) begin fails++; $display("FAIL reset_retry_cnt: got %0d want 0", retry_cnt); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic test_connect();
    do_reset();
    adv_time = 24'd0; conn_time = 24'd0;
    start_adv();
    send_str({"OK+CONN", ADDR_STR});
    repeat (10) @(posedge clk); #1;
    tests++; if (wr_cyc.size() != 6) begin fails++; $display("FAIL conn_wr_count: got %0d want 6", wr_cyc.size()); end
    else for (int i = 0; i < 6; i++) begin
      tests++; if (wr_addr[i] !== 8'h20 + 8'(i)) begin fails++; $display("FAIL conn_wr_addr[%0d]: got %h want %h", i, wr_addr[i], 8'h20 + 8'(i)); end
      tests++; if (wr_data[i] !== exp_b[i]) begin fails++; $display("FAIL conn_wr_data[%0d]: got %h want %h", i, wr_data[i], exp_b[i]); end
      tests++; if (wr_cyc[i] != lf_cyc + 1 + i) begin fails++; $display("FAIL conn_wr_cycle[%0d]: got %0d want %0d", i, wr_cyc[i], lf_cyc + 1 + i); end
    end
    tests++; if (conn_cyc != lf_cyc + 7) begin fails++; $display("FAIL conn_rise_cycle: got %0d want %0d", conn_cyc, lf_cyc + 7); end
    tests++; if (connected !== 1'b1) begin fails++; $display("FAIL conn_level: got %b want 1", connected); end
  endtask

  task automatic test_disconnect();
    clear_logs();
    send_str("OK+LOST");
    repeat (4) @(posedge clk); #1;
    tests++; if (dc_n != 1) begin fails++; $display("FAIL lost_disc_pulses: got %0d want 1", dc_n); end
    tests++; if (disc_cause !== 2'd2) begin fails++; $display("FAIL lost_cause: got %0d want 2", disc_cause); end
    tests++; if (connected !== 1'b0) begin fails++; $display("FAIL lost_connected: got %b want 0", connected); end
    conn_time = 24'd50;
    start_adv();
    send_str({"OK+CONN", ADDR_STR});
    clear_logs();
    for (int k = 0; k < 120 && dc_n == 0; k++) @(posedge clk);
    #1;
    tests++; if (dc_n != 1) begin fails++; $display("FAIL inact_disc_pulses: got %0d want 1", dc_n); end
    tests++; if (disc_cause !== 2'd3) begin fails++; $display("FAIL inact_cause: got %0d want 3", disc_cause); end
    tests++; if (dc_cyc - conn_cyc != 50) begin fails++; $display("FAIL inact_delay: got %0d want 50", dc_cyc - conn_cyc); end
    conn_time = 24'd0;
  endtask

  task automatic test_retry();
    do_reset();
    adv_time = 24'd100;
    start_adv();
    for (int k = 0; k < 600 && to_n == 0; k++) @(posedge clk);
    repeat (2) @(posedge clk); #1;
    tests++; if (to_n != 1) begin fails++; $display("FAIL retry_timeout_pulses: got %0d want 1", to_n); end
    tests++; if (rs_cyc.size() != 3) begin fails++; $display("FAIL retry_restart_count: got %0d want 3", rs_cyc.size()); end
    else begin
      tests++; if (rs_cyc[0] - set_cyc != 101) begin fails++; $display("FAIL retry_first: got %0d want 101", rs_cyc[0] - set_cyc); end
      for (int i = 1; i < 3; i++) begin
        tests++; if (rs_cyc[i] - rs_cyc[i-1] != 100) begin fails++; $display("FAIL retry_gap[%0d]: got %0d want 100", i, rs_cyc[i] - rs_cyc[i-1]); end
      end
      for (int i = 0; i < 3; i++) begin
        tests++; if (rs_cnt[i] != i + 1) begin fails++; $display("FAIL retry_cnt[%0d]: got %0d want %0d", i, rs_cnt[i], i + 1); end
      end
      tests++; if (to_cyc - rs_cyc[2] != 100) begin fails++; $display("FAIL retry_timeout_gap: got %0d want 100", to_cyc - rs_cyc[2]); end
    end
    tests++; if (retry_cnt !== 2'd0) begin fails++; $display("FAIL retry_cleared: got %0d want 0", retry_cnt); end
    adv_time = 24'd0;
  endtask

  task automatic test_addr_err();
    do_reset();
    start_adv();
    send_str("OK+CONN:A1G2");
    repeat (3) @(posedge clk); #1;
    tests++; if (ae_n != 1) begin fails++; $display("FAIL adderr_pulses: got %0d want 1", ae_n); end
    tests++; if (ae_cyc != g_cyc + 1) begin fails++; $display("FAIL adderr_cycle: got %0d want %0d", ae_cyc, g_cyc + 1); end
    tests++; if (wr_cyc.size() != 0) begin fails++; $display("FAIL adderr_no_writes: got %0d want 0", wr_cyc.size()); end
    send_str(ADDR_STR);
    repeat (10) @(posedge clk); #1;
    tests++; if (wr_cyc.size() != 6) begin fails++; $display("FAIL adderr_retry_writes: got %0d want 6", wr_cyc.size()); end
    else begin
      tests++; if (wr_data[0] !== 8'hA1 || wr_data[5] !== 8'hF6) begin fails++; $display("FAIL adderr_retry_data: got %h..%h want a1..f6", wr_data[0], wr_data[5]); end
    end
    tests++; if (connected !== 1'b1) begin fails++; $display("FAIL adderr_connected: got %b want 1", connected); end
  endtask

  task automatic test_pattern_vs_expiry();
    do_reset();
    start_adv();
    send_str({"OK+CONN", ADDR_STR});
    repeat (8) @(posedge clk); #1;
    conn_time = 24'd5;
    send_str("OK+DIS");
    repeat (4) @(posedge clk); #1;
    send_byte(8'h43);
    repeat (3) @(posedge clk); #1;
    tests++; if (dc_n != 1) begin fails++; $display("FAIL prio_disc_pulses: got %0d want 1", dc_n); end
    tests++; if (disc_cause !== 2'd1) begin fails++; $display("FAIL prio_cause: got %0d want 1", disc_cause); end
    conn_time = 24'd0;
  endtask

  task automatic test_reset_mid_store();
    do_reset();
    start_adv();
    send_str({"OK+CONN", ADDR_STR});
    @(negedge clk); @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    tests++; if (bus.reg_wr_en !== 1'b0 || bus.reg_wr_addr !== 8'h20 || bus.reg_wr_data !== 8'h00) begin fails++;
      $display("FAIL midstore_wr_port: got %b/%h/%h want 0/20/00", bus.reg_wr_en, bus.reg_wr_addr, bus.reg_wr_data); end
    tests++; if (bus.rx_ready !== 1'b1 || connected !== 1'b0) begin fails++; $display("FAIL midstore_levels: got rdy=%b conn=%b want 1/0", bus.rx_ready, connected); end
    tests++; if (wr_cyc.size() != 2) begin fails++; $display("FAIL midstore_writes_before: got %0d want 2", wr_cyc.size()); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk); #1;
    tests++; if (wr_cyc.size() != 2) begin fails++; $display("FAIL midstore_writes_after: got %0d want 2", wr_cyc.size()); end
    tests++; if (connected !== 1'b0) begin fails++; $display("FAIL midstore_connected: got %b want 0", connected); end
  endtask

  initial begin
    bus.rx_data = 8'h00; bus.rx_valid = 1'b0;
    clear_logs();
    test_reset();
    test_connect();
    test_disconnect();
    test_retry();
    test_addr_err();
    test_pattern_vs_expiry();
    test_reset_mid_store();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
